rgb2bayer_3x3: RTL and testbench
================================

# rgb2bayer_3x3

Re-mosaics a pixel-parallel RGB stream into a single-channel Bayer raw stream with the same V_Sync/valid framing that the demosaic path consumes. It sits in front of the demosaic stage as a loop-back and regression source: camera-less test patterns or processed RGB frames are converted back to raw so the demosaic path can be exercised end-to-end. It also checks line and frame geometry against the configured size and reports violations.

## Interface
- DATA_WIDTH, 8, bits per colour component and per raw sample
- I_W, 1922, pixels per line
- I_H, 1082, lines per frame
- BAYER_PAT, 2'd3, colour of pixel (0,0): 0 BGGR, 1 GBRG, 2 GRBG, 3 RGGB

- I_Clk  in  1  clock
- I_Rst  in  1  reset, synchronous, active-high
- I_V_Sync  in  1  frame sync; rising edge starts a frame
- I_RGB_Vaild  in  1  pixel valid; high for one pixel per cycle within a line
- I_RGB_Data_r / _g / _b  in  DATA_WIDTH each  colour components
- O_V_Sync  out  1  I_V_Sync delayed 1 cycle
- O_Raw_Vaild  out  1  I_RGB_Vaild delayed 1 cycle
- O_Raw_Data  out  DATA_WIDTH  selected component; 0 when O_Raw_Vaild low
- O_Line_Err  out  1  1-cycle pulse: short line detected
- O_Frame_Err  out  1  1-cycle pulse: previous frame line count != I_H
- O_Frame_Cnt  out  16  frames started since reset, wraps

## Operation
- Edge detect: Pose_V_Sync = I_V_Sync & !r1_V_Sync; Nege_Vaild = !I_RGB_Vaild & r1_Vaild.
- H_cnt (width clog2(I_W)): cleared on Pose_V_Sync or Nege_Vaild; otherwise +1 per valid pixel, wraps I_W-1 -> 0.
- Line end event: Nege_Vaild, or valid pixel accepted at H_cnt == I_W-1 (continuous valid splits into I_W-pixel lines).
- V_cnt (width clog2(I_H)): cleared on Pose_V_Sync; +1 per line end, wraps I_H-1 -> 0.
- Parity p = {V_cnt[0], H_cnt[0]} of current pixel; effective phase q = p XOR pattern offset: RGGB 2'b00, GRBG 2'b01, GBRG 2'b10, BGGR 2'b11.
- q = 00 -> R; 01 or 10 -> G; 11 -> B. Registered into O_Raw_Data when valid, else 0.
- Line check: on Nege_Vaild with H_cnt != 0 (pixels in line < I_W), O_Line_Err pulses next cycle. Line ending by I_W wrap never errors. Nege_Vaild with H_cnt == 0 after an exact wrap is not a line end and does not count.
- Frame check: Line_Total counter (clog2(I_H)+1 bits, saturating) counts line ends since last Pose_V_Sync. On Pose_V_Sync, if frame_seen and Line_Total (including a line end in the same cycle) != I_H, O_Frame_Err pulses next cycle. Then Line_Total cleared, frame_seen set, O_Frame_Cnt +1.
- Pose_V_Sync coinciding with a valid pixel: pixel is (0,0) of the new frame, coloured with p=00.
- Pose_V_Sync coinciding with Nege_Vaild: line check of ending line still performed; counters then cleared.

## Timing
- Latency: O_Raw_Data, O_Raw_Vaild, O_V_Sync all exactly 1 cycle after inputs; mutually aligned.
- No backpressure; one pixel per cycle accepted.
- Error pulses are 1 cycle wide, asserted the cycle after the detecting edge.
- Reset: all outputs 0, H_cnt/V_cnt/Line_Total 0, frame_seen 0, r1 registers 0. First Pose_V_Sync after reset increments O_Frame_Cnt to 1 and never raises O_Frame_Err.
- Reset mid-line/mid-frame: outputs 0 the following cycle; input valid still high after reset release is treated as pixel (0,0) of line 0; no Nege_Vaild error generated from pre-reset state.

## Test plan
- I_W=4, I_H=4, RGGB, pixel (v,h) r=16v+h, g=0x40+16v+h, b=0x80+16v+h: raw line 0 = 0x00,0x41,0x02,0x43; line 1 = 0x50,0x91,0x52,0x93; 1-cycle latency, no errors.
- Same frame with BAYER_PAT=0 (BGGR): line 0 = 0x80,0x41,0x82,0x43; line 1 = 0x50,0x11,0x52,0x13.
- Line of 3 valid pixels in line 2 -> O_Line_Err single pulse 1 cycle after valid falls; at next V_Sync rise O_Frame_Err stays 0 (4 lines counted).
- Frame of 3 lines then V_Sync rise -> O_Frame_Err pulse; O_Frame_Cnt 1 -> 2.
- Continuous valid for 8 pixels -> two lines of 4, V_cnt 0 -> 2, no O_Line_Err; line 1 colours follow v=1 parity.
- I_Rst asserted 1 cycle mid line 1 -> all outputs 0 next cycle, O_Frame_Cnt 0; next V_Sync rise gives O_Frame_Cnt=1, no O_Frame_Err.

Source files
------------

// File: rtl/rgb2bayer_3x3.sv
// rtl/rgb2bayer_3x3.sv - RGB to Bayer re-mosaic with line/frame geometry checking
// One registered stage: outputs are aligned 1 cycle behind the inputs.
module rgb2bayer_3x3 #(
  parameter int          DATA_WIDTH = 8,
  parameter int          I_W        = 1922,
  parameter int          I_H        = 1082,
  parameter logic [1:0]  BAYER_PAT  = 2'd3
) (
  input  logic                  I_Clk,
  input  logic                  I_Rst,
  input  logic                  I_V_Sync,
  input  logic                  I_RGB_Vaild,
  input  logic [DATA_WIDTH-1:0] I_RGB_Data_r,
  input  logic [DATA_WIDTH-1:0] I_RGB_Data_g,
  input  logic [DATA_WIDTH-1:0] I_RGB_Data_b,
  output logic                  O_V_Sync,
  output logic                  O_Raw_Vaild,
  output logic [DATA_WIDTH-1:0] O_Raw_Data,
  output logic                  O_Line_Err,
  output logic                  O_Frame_Err,
  output logic [15:0]           O_Frame_Cnt
);

  localparam int HW  = (I_W > 1) ? $clog2(I_W) : 1;
  localparam int VW  = (I_H > 1) ? $clog2(I_H) : 1;
  localparam int LTW = VW + 1;

  localparam logic [HW-1:0]  H_LAST  = HW'(I_W - 1);
  localparam logic [VW-1:0]  V_LAST  = VW'(I_H - 1);
  localparam logic [LTW-1:0] LT_GOAL = LTW'(I_H);
  localparam logic [LTW-1:0] LT_MAX  = '1;

  // Phase offset so that phase 00 always lands on the red site.
  localparam logic [1:0] PAT_OFS = 2'b11 ^ BAYER_PAT;

  logic                  r1_V_Sync;
  logic                  r1_Vaild;
  logic [HW-1:0]         H_cnt;
  logic [VW-1:0]         V_cnt;
  logic [LTW-1:0]        Line_Total;
  logic                  frame_seen;

  logic                  pose_v_sync;
  logic                  nege_vaild;
  logic [HW-1:0]         h_eff;
  logic [VW-1:0]         v_eff;
  logic                  end_short;
  logic                  end_wrap;
  logic [1:0]            phase;
  logic [DATA_WIDTH-1:0] pix_sel;
  logic [LTW-1:0]        lt_close;
  logic [HW-1:0]         h_next;
  logic [VW-1:0]         v_next;
  logic [LTW-1:0]        lt_next;
  logic                  frame_bad;

  always_comb begin
    pose_v_sync = I_V_Sync & ~r1_V_Sync;
    nege_vaild  = ~I_RGB_Vaild & r1_Vaild;

    // A frame start makes the current pixel (0,0) of the new frame.
    h_eff = pose_v_sync ? '0 : H_cnt;
    v_eff = pose_v_sync ? '0 : V_cnt;

    end_short = nege_vaild && (H_cnt != '0);
    end_wrap  = I_RGB_Vaild && (h_eff == H_LAST);

    phase = {v_eff[0], h_eff[0]} ^ PAT_OFS;
    case (phase)
      2'b00:   pix_sel = I_RGB_Data_r;
      2'b11:   pix_sel = I_RGB_Data_b;
      default: pix_sel = I_RGB_Data_g;
    endcase

    lt_close = Line_Total;
    if (end_short && (Line_Total != LT_MAX))
      lt_close = Line_Total + LTW'(1);
    frame_bad = pose_v_sync && frame_seen && (lt_close != LT_GOAL);

    h_next = H_cnt;
    if (I_RGB_Vaild)
      h_next = (h_eff == H_LAST) ? '0 : h_eff + HW'(1);
    else if (pose_v_sync || nege_vaild)
      h_next = '0;

    // A short line that ends on the frame edge belongs to the old frame.
    v_next = v_eff;
    if (end_wrap || (end_short && !pose_v_sync))
      v_next = (v_eff == V_LAST) ? '0 : v_eff + VW'(1);

    if (pose_v_sync)
      lt_next = end_wrap ? LTW'(1) : '0;
    else if ((end_short || end_wrap) && (Line_Total != LT_MAX))
      lt_next = Line_Total + LTW'(1);
    else
      lt_next = Line_Total;
  end

  always_ff @(posedge I_Clk) begin
    if (I_Rst) begin
      r1_V_Sync   <= 1'b0;
      r1_Vaild    <= 1'b0;
      H_cnt       <= '0;
      V_cnt       <= '0;
      Line_Total  <= '0;
      frame_seen  <= 1'b0;
      O_V_Sync    <= 1'b0;
      O_Raw_Vaild <= 1'b0;
      O_Raw_Data  <= '0;
      O_Line_Err  <= 1'b0;
      O_Frame_Err <= 1'b0;
      O_Frame_Cnt <= '0;
    end else begin
      r1_V_Sync   <= I_V_Sync;
      r1_Vaild    <= I_RGB_Vaild;
      H_cnt       <= h_next;
      V_cnt       <= v_next;
      Line_Total  <= lt_next;
      O_V_Sync    <= I_V_Sync;
      O_Raw_Vaild <= I_RGB_Vaild;
      O_Raw_Data  <= I_RGB_Vaild ? pix_sel : '0;
      O_Line_Err  <= end_short;
      O_Frame_Err <= frame_bad;
      if (pose_v_sync) begin
        frame_seen  <= 1'b1;
        O_Frame_Cnt <= O_Frame_Cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rgb2bayer_3x3.sv
// tb/tb_rgb2bayer_3x3.sv - scoreboard bench for rgb2bayer_3x3 (4x4 frame, RGGB and BGGR)
module tb_rgb2bayer_3x3;

  logic       I_Clk = 1'b0;
  logic       I_Rst = 1'b1;
  logic       I_V_Sync = 1'b0;
  logic       I_RGB_Vaild = 1'b0;
  logic [7:0] I_RGB_Data_r = '0;
  logic [7:0] I_RGB_Data_g = '0;
  logic [7:0] I_RGB_Data_b = '0;

  logic        vs_a, vld_a, le_a, fe_a;
  logic [7:0]  data_a;
  logic [15:0] fc_a;
  logic        vs_b, vld_b, le_b, fe_b;
  logic [7:0]  data_b;
  logic [15:0] fc_b;

  always #5 I_Clk = ~I_Clk;

  rgb2bayer_3x3 #(.DATA_WIDTH(8), .I_W(4), .I_H(4), .BAYER_PAT(2'd3)) dut_rggb (
    .I_Clk(I_Clk), .I_Rst(I_Rst), .I_V_Sync(I_V_Sync), .I_RGB_Vaild(I_RGB_Vaild),
    .I_RGB_Data_r(I_RGB_Data_r), .I_RGB_Data_g(I_RGB_Data_g), .I_RGB_Data_b(I_RGB_Data_b),
    .O_V_Sync(vs_a), .O_Raw_Vaild(vld_a), .O_Raw_Data(data_a),
    .O_Line_Err(le_a), .O_Frame_Err(fe_a), .O_Frame_Cnt(fc_a)
  );

  rgb2bayer_3x3 #(.DATA_WIDTH(8), .I_W(4), .I_H(4), .BAYER_PAT(2'd0)) dut_bggr (
    .I_Clk(I_Clk), .I_Rst(I_Rst), .I_V_Sync(I_V_Sync), .I_RGB_Vaild(I_RGB_Vaild),
    .I_RGB_Data_r(I_RGB_Data_r), .I_RGB_Data_g(I_RGB_Data_g), .I_RGB_Data_b(I_RGB_Data_b),
    .O_V_Sync(vs_b), .O_Raw_Vaild(vld_b), .O_Raw_Data(data_b),
    .O_Line_Err(le_b), .O_Frame_Err(fe_b), .O_Frame_Cnt(fc_b)
  );

  typedef struct {
    logic        vs;
    logic        vld;
    logic [7:0]  da;
    logic [7:0]  db;
    logic        le;
    logic        fe;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Raw sample of pixel (v,h) for a given pattern, from the test-plan pixel values.
  function automatic logic [7:0] px(input logic [1:0] pat, input int v, input int h);
    logic [7:0] r, g, b;
    logic [1:0] ofs, q;
    r = 8'(16 * v + h);
    g = 8'(8'h40 + 16 * v + h);
    b = 8'(8'h80 + 16 * v + h);
    case (pat)
      2'd3:    ofs = 2'b00;
      2'd2:    ofs = 2'b01;
      2'd1:    ofs = 2'b10;
      default: ofs = 2'b11;
    endcase
    q = {v[0], h[0]} ^ ofs;
    if (q == 2'b00)      px = r;
    else if (q == 2'b11) px = b;
    else                 px = g;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge I_Clk) begin
    #2;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rggb_vsync", {15'd0, vs_a}, {15'd0, e.vs});
      chk("rggb_valid", {15'd0, vld_a}, {15'd0, e.vld});
      chk("rggb_data", {8'd0, data_a}, {8'd0, e.da});
      chk("rggb_line_err", {15'd0, le_a}, {15'd0, e.le});
      chk("rggb_frame_err", {15'd0, fe_a}, {15'd0, e.fe});
      chk("rggb_frame_cnt", fc_a, e.fc);
      chk("bggr_vsync", {15'd0, vs_b}, {15'd0, e.vs});
      chk("bggr_valid", {15'd0, vld_b}, {15'd0, e.vld});
      chk("bggr_data", {8'd0, data_b}, {8'd0, e.db});
      chk("bggr_line_err", {15'd0, le_b}, {15'd0, e.le});
      chk("bggr_frame_err", {15'd0, fe_b}, {15'd0, e.fe});
      chk("bggr_frame_cnt", fc_b, e.fc);
    end
  end

  // One input cycle; expected outputs describe the cycle after this one.
  task automatic cyc(input logic rst, input logic vs, input logic vld, input int v, input int h,
                     input logic le, input logic fe, input logic [15:0] fc);
    exp_t e;
    @(negedge I_Clk);
    I_Rst        = rst;
    I_V_Sync     = vs;
    I_RGB_Vaild  = vld;
    I_RGB_Data_r = vld ? 8'(16 * v + h) : 8'hAA;
    I_RGB_Data_g = vld ? 8'(8'h40 + 16 * v + h) : 8'h55;
    I_RGB_Data_b = vld ? 8'(8'h80 + 16 * v + h) : 8'hCC;
    e.vs  = !rst && vs;
    e.vld = !rst && vld;
    e.da  = (!rst && vld) ? px(2'd3, v, h) : 8'h00;
    e.db  = (!rst && vld) ? px(2'd0, v, h) : 8'h00;
    e.le  = le;
    e.fe  = fe;
    e.fc  = fc;
    exp_q.push_back(e);
  endtask

  // n valid pixels of line v, then one idle cycle carrying the expected line error.
  task automatic line(input int v, input int n, input logic le, input logic [15:0] fc);
    for (int h = 0; h < n; h++) cyc(1'b0, 1'b0, 1'b1, v, h, 1'b0, 1'b0, fc);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, le, 1'b0, fc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 16'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'd0);

    // Frame A: short line 2 still gives 4 line ends
    cyc(0, 1, 0, 0, 0, 0, 0, 16'd1);
    cyc(0, 1, 0, 0, 0, 0, 0, 16'd1);
    line(0, 4, 0, 16'd1);
    line(1, 4, 0, 16'd1);
    line(2, 3, 1, 16'd1);
    line(3, 4, 0, 16'd1);

    // Frame B: continuous 8-pixel run splits into lines 0 and 1; 3 lines total
    cyc(0, 1, 0, 0, 0, 0, 0, 16'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'd2);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i / 4, i % 4, 0, 0, 16'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'd2);
    line(2, 4, 0, 16'd2);

    // Frame C starts on a valid pixel; previous frame had 3 lines
    cyc(0, 1, 1, 0, 0, 0, 1, 16'd3);
    for (int h = 1; h < 4; h++) cyc(0, 0, 1, 0, h, 0, 0, 16'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'd3);
    cyc(0, 0, 1, 1, 0, 0, 0, 16'd3);
    cyc(0, 0, 1, 1, 1, 0, 0, 16'd3);

    // Reset mid line 1, valid stays high across release
    cyc(1, 0, 1, 1, 2, 0, 0, 16'd0);
    line(0, 4, 0, 16'd0);

    cyc(0, 1, 0, 0, 0, 0, 0, 16'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'd1);
    line(0, 2, 1, 16'd1);
    for (int h = 0; h < 3; h++) cyc(0, 0, 1, 1, h, 0, 0, 16'd1);
    // Frame start coinciding with a short line ending: both errors fire
    cyc(0, 1, 0, 0, 0, 1, 1, 16'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'd2);
    line(0, 4, 0, 16'd2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge I_Clk);
    @(negedge I_Clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
